// File: rtl/conv_row_sched_if.sv
// Scheduler <-> environment bundle: layer config, feature-ready and
// pass-done handshakes in; address-controller drive and accumulator /
// writeback markers out. master = scheduler side, slave = environment.
interface conv_row_sched_if #(
    parameter int AXIWIDTH   = 32,
    parameter int DEPTHWIDTH = 9,
    parameter int KWIDTH     = 4
);
    logic                  I_ap_start;
    logic [AXIWIDTH-1:0]   I_ky_num;
    logic [AXIWIDTH-1:0]   I_oheight_num;
    logic [AXIWIDTH-1:0]   I_iheight_num;
    logic [AXIWIDTH-1:0]   I_stride;
    logic [AXIWIDTH-1:0]   I_pad;
    logic                  I_f_rdy;
    logic                  I_pass_done;
    logic                  O_ap_start;
    logic                  O_compute_en;
    logic [KWIDTH-1:0]     O_ky;
    logic [DEPTHWIDTH:0]   O_hindex;
    logic                  O_acc_first;
    logic                  O_acc_last;
    logic                  O_row_done;
    logic                  O_ap_done;
    logic                  O_busy;
    logic                  O_err;

    modport master (
        input  I_ap_start, I_ky_num, I_oheight_num, I_iheight_num, I_stride, I_pad,
               I_f_rdy, I_pass_done,
        output O_ap_start, O_compute_en, O_ky, O_hindex, O_acc_first, O_acc_last,
               O_row_done, O_ap_done, O_busy, O_err
    );

    modport slave (
        output I_ap_start, I_ky_num, I_oheight_num, I_iheight_num, I_stride, I_pad,
               I_f_rdy, I_pass_done,
        input  O_ap_start, O_compute_en, O_ky, O_hindex, O_acc_first, O_acc_last,
               O_row_done, O_ap_done, O_busy, O_err
    );
endinterface

// File: rtl/conv_row_sched.sv
// conv_row_sched: walks (output row, kernel row) pairs, skips passes that
// fall into top/bottom padding, waits for the feature row, then opens one
// address-controller pass and waits for its done pulse.
// Optional watchdog on the RUN state: define SCHED_TIMEOUT_EN.
module conv_row_sched #(
    parameter int AXIWIDTH   = 32,
    parameter int DEPTHWIDTH = 9,
    parameter int KWIDTH     = 4,
    parameter int TIMEOUT    = 65535
) (
    input logic              I_clk,
    input logic              I_rst,
    conv_row_sched_if.master bus
);
    // one extra bit for sign, one for headroom above IH
    localparam int RW = DEPTHWIDTH + 2;

    typedef enum logic [2:0] {IDLE, CALC, WAIT_RDY, START, RUN, NEXT, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   start_d1, start_d2, start_edge;
    logic [KWIDTH-1:0]      kh_m1, ky;
    logic [DEPTHWIDTH-1:0]  oh_m1, oh;
    logic signed [RW-1:0]   ih_s, ih_m1_s, stride_s, row_base, row;
    logic                   first_pend, last_r;
    logic                   row_skip, row_last, timeout;
    logic                   unused_cfg;

    assign start_edge = start_d1 & ~start_d2;
    assign row        = row_base + $signed({{(RW-KWIDTH){1'b0}}, ky});
    assign row_skip   = row[RW-1] || (row >= ih_s);
    // rows only grow with ky, so once row reaches IH-1 every later ky is padding
    assign row_last   = (ky == kh_m1) || (row >= ih_m1_s);

    assign unused_cfg = ^{bus.I_ky_num[AXIWIDTH-1:KWIDTH],
                          bus.I_oheight_num[AXIWIDTH-1:DEPTHWIDTH],
                          bus.I_iheight_num[AXIWIDTH-1:DEPTHWIDTH+1],
                          bus.I_stride[AXIWIDTH-1:DEPTHWIDTH+1],
                          bus.I_pad[AXIWIDTH-1:DEPTHWIDTH]};

`ifdef SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // watchdog: cleared outside RUN, counts RUN cycles
    always_ff @(posedge I_clk) begin
        if (I_rst || state != RUN) wd_cnt <= '0;
        else                       wd_cnt <= wd_cnt + 16'd1;
    end

    assign timeout = (state == RUN) && !bus.I_pass_done && (wd_cnt == 16'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge I_clk) begin
        if (I_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_edge) state_nxt = CALC;
            CALC:     state_nxt = row_skip ? NEXT : WAIT_RDY;
            WAIT_RDY: if (bus.I_f_rdy) state_nxt = START;
            START:    state_nxt = RUN;
            RUN: begin
                if (bus.I_pass_done) state_nxt = NEXT;
                else if (timeout)    state_nxt = IDLE;
            end
            NEXT: begin
                if (ky != kh_m1)      state_nxt = CALC;
                else if (oh == oh_m1) state_nxt = DONE;
                else                  state_nxt = CALC;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // counters, latched config and registered outputs
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            start_d1         <= 1'b0;
            start_d2         <= 1'b0;
            kh_m1            <= '0;
            oh_m1            <= '0;
            ky               <= '0;
            oh               <= '0;
            ih_s             <= '0;
            ih_m1_s          <= '0;
            stride_s         <= '0;
            row_base         <= '0;
            first_pend       <= 1'b0;
            last_r           <= 1'b0;
            bus.O_ap_start   <= 1'b0;
            bus.O_compute_en <= 1'b0;
            bus.O_ky         <= '0;
            bus.O_hindex     <= '0;
            bus.O_acc_first  <= 1'b0;
            bus.O_acc_last   <= 1'b0;
            bus.O_row_done   <= 1'b0;
            bus.O_ap_done    <= 1'b0;
            bus.O_busy       <= 1'b0;
            bus.O_err        <= 1'b0;
        end else begin
            start_d1 <= bus.I_ap_start;
            start_d2 <= start_d1;

            case (state)
                IDLE: if (start_edge) begin
                    kh_m1      <= bus.I_ky_num[KWIDTH-1:0] - 1'b1;
                    oh_m1      <= bus.I_oheight_num[DEPTHWIDTH-1:0] - 1'b1;
                    ih_s       <= $signed({1'b0, bus.I_iheight_num[DEPTHWIDTH:0]});
                    ih_m1_s    <= $signed({1'b0, bus.I_iheight_num[DEPTHWIDTH:0]} - 1'b1);
                    stride_s   <= $signed({1'b0, bus.I_stride[DEPTHWIDTH:0]});
                    row_base   <= $signed({RW{1'b0}} - {2'b00, bus.I_pad[DEPTHWIDTH-1:0]});
                    ky         <= '0;
                    oh         <= '0;
                    first_pend <= 1'b1;
                end
                CALC: if (!row_skip) begin
                    bus.O_hindex <= row[DEPTHWIDTH:0];
                    bus.O_ky     <= ky;
                    last_r       <= row_last;
                end
                RUN: if (bus.I_pass_done) first_pend <= 1'b0;
                NEXT: begin
                    if (ky != kh_m1) begin
                        ky <= ky + 1'b1;
                    end else begin
                        ky         <= '0;
                        oh         <= oh + 1'b1;
                        row_base   <= row_base + stride_s;
                        first_pend <= 1'b1;
                    end
                end
                default: ;
            endcase

            bus.O_ap_start   <= (state_nxt == START);
            bus.O_compute_en <= (state_nxt == START) || (state_nxt == RUN);
            bus.O_acc_first  <= ((state_nxt == START) || (state_nxt == RUN)) && first_pend;
            bus.O_acc_last   <= ((state_nxt == START) || (state_nxt == RUN)) && last_r;
            bus.O_row_done   <= (state == NEXT) && (ky == kh_m1);
            bus.O_ap_done    <= (state_nxt == DONE);
            bus.O_busy       <= (state_nxt != IDLE);
            bus.O_err        <= timeout;
        end
    end
endmodule

// File: tb/tb_conv_row_sched.sv
// Scoreboard bench for conv_row_sched: stimulus pushes hand-computed pass /
// row_done / ap_done events, a monitor pops them as the DUT emits them.
module tb_conv_row_sched;
    localparam int AW = 32, DW = 9, KW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pd_resp = 1'b0, pd_stray = 1'b0;
    bit   pd_auto = 1'b1;
    int   n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    conv_row_sched_if #(.AXIWIDTH(AW), .DEPTHWIDTH(DW), .KWIDTH(KW)) bus ();

    assign bus.I_pass_done = pd_resp | pd_stray;

    conv_row_sched #(.AXIWIDTH(AW), .DEPTHWIDTH(DW), .KWIDTH(KW), .TIMEOUT(100)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    typedef enum logic [1:0] {EV_PASS, EV_ROW, EV_LAYER} ev_kind_t;
    typedef struct packed {
        ev_kind_t      kind;
        logic [KW-1:0] ky;
        logic [DW:0]   h;
        logic          first;
        logic          last;
    } ev_t;

    ev_t exp_q[$];

    function automatic ev_t mk(ev_kind_t k, int ky, int h, bit f, bit l);
        ev_t e;
        e.kind = k; e.ky = KW'(ky); e.h = (DW+1)'(h); e.first = f; e.last = l;
        return e;
    endfunction

    task automatic push_pass(int ky, int h, bit f, bit l);
        exp_q.push_back(mk(EV_PASS, ky, h, f, l));
    endtask

    task automatic push_row();
        exp_q.push_back(mk(EV_ROW, 0, 0, 1'b0, 1'b0));
    endtask

    task automatic push_layer();
        exp_q.push_back(mk(EV_LAYER, 0, 0, 1'b0, 1'b0));
    endtask

    task automatic check_ev(ev_t got, string name);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s unexpected: got kind=%0d ky=%0d h=%0d f=%0b l=%0b, expected nothing",
                     name, got.kind, got.ky, got.h, got.first, got.last);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s: got kind=%0d ky=%0d h=%0d f=%0b l=%0b, expected kind=%0d ky=%0d h=%0d f=%0b l=%0b",
                         name, got.kind, got.ky, got.h, got.first, got.last,
                         e.kind, e.ky, e.h, e.first, e.last);
            end
        end
    endtask

    task automatic check(string name, longint got, longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // monitor: every DUT event consumes one expected entry, in emission order
    always @(negedge clk) begin
        if (bus.O_ap_start)
            check_ev(mk(EV_PASS, int'(bus.O_ky), int'(bus.O_hindex), bus.O_acc_first, bus.O_acc_last), "pass");
        if (bus.O_row_done) check_ev(mk(EV_ROW, 0, 0, 1'b0, 1'b0), "row_done");
        if (bus.O_ap_done)  check_ev(mk(EV_LAYER, 0, 0, 1'b0, 1'b0), "ap_done");
    end

    // address-controller stand-in: pass_done 5 cycles after each pass start
    initial forever begin
        @(negedge clk);
        if (bus.O_ap_start && pd_auto) begin
            repeat (5) @(negedge clk);
            pd_resp = 1'b1;
            @(negedge clk);
            pd_resp = 1'b0;
        end
    end

    task automatic do_start(int kh, int oh, int ih, int st, int pad);
        bus.I_ky_num = AW'(kh); bus.I_oheight_num = AW'(oh); bus.I_iheight_num = AW'(ih);
        bus.I_stride = AW'(st); bus.I_pad = AW'(pad);
        @(negedge clk); bus.I_ap_start = 1'b1;
        @(negedge clk); bus.I_ap_start = 1'b0;
    endtask

    task automatic wait_done(string name);
        int c = 0;
        while ((exp_q.size() != 0 || bus.O_busy) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check({name, "_drained"}, (c < 500) ? 0 : exp_q.size() + 1000, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [21:0] all_outs();
        return {bus.O_ap_start, bus.O_compute_en, bus.O_ky, bus.O_hindex, bus.O_acc_first,
                bus.O_acc_last, bus.O_row_done, bus.O_ap_done, bus.O_busy, bus.O_err};
    endfunction

    initial begin
        #300000;
        $display("FAIL global_time_limit: run did not finish, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int hits, c;
        bit err_seen;
        bus.I_ap_start = 1'b0; bus.I_f_rdy = 1'b1;
        bus.I_ky_num = '0; bus.I_oheight_num = '0; bus.I_iheight_num = '0;
        bus.I_stride = '0; bus.I_pad = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // KH=3 OH=2 IH=4 stride 1 pad 0, plus a stray start while busy
        push_pass(0,0,1,0); push_pass(1,1,0,0); push_pass(2,2,0,1); push_row();
        push_pass(0,1,1,0); push_pass(1,2,0,0); push_pass(2,3,0,1); push_row(); push_layer();
        do_start(3, 2, 4, 1, 0);
        repeat (8) @(negedge clk);
        bus.I_ap_start = 1'b1; @(negedge clk); bus.I_ap_start = 1'b0;
        wait_done("t1_basic");
        check("t1_idle_busy", bus.O_busy, 0);

        // pad=1: row 0 skips ky0, row 3 skips ky2
        push_pass(1,0,1,0); push_pass(2,1,0,1); push_row();
        push_pass(0,0,1,0); push_pass(1,1,0,0); push_pass(2,2,0,1); push_row();
        push_pass(0,1,1,0); push_pass(1,2,0,0); push_pass(2,3,0,1); push_row();
        push_pass(0,2,1,0); push_pass(1,3,0,1); push_row(); push_layer();
        do_start(3, 4, 4, 1, 1);
        wait_done("t2_pad");

        // stride 2
        push_pass(0,0,1,0); push_pass(1,1,0,1); push_row();
        push_pass(0,2,1,0); push_pass(1,3,0,1); push_row(); push_layer();
        do_start(2, 2, 4, 2, 0);
        wait_done("t3_stride");

        // KH=1 OH=1 single pass
        push_pass(0,0,1,1); push_row(); push_layer();
        do_start(1, 1, 4, 1, 0);
        wait_done("t4_single");

        // f_rdy held low with stray pass_done pulses
        bus.I_f_rdy = 1'b0;
        push_pass(0,0,1,1); push_row(); push_layer();
        do_start(1, 1, 4, 1, 0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            pd_stray = (i == 5 || i == 10);
            @(negedge clk);
            if (bus.O_ap_start) hits++;
        end
        pd_stray = 1'b0;
        check("t5_no_start_while_not_rdy", hits, 0);
        check("t5_busy_waiting", bus.O_busy, 1);
        bus.I_f_rdy = 1'b1;
        @(negedge clk);
        check("t5_start_after_rdy", bus.O_ap_start, 1);
        wait_done("t5_frdy");

        // reset mid-RUN
        pd_auto = 1'b0;
        push_pass(0,0,1,0);
        do_start(3, 2, 4, 1, 0);
        c = 0;
        while (!bus.O_compute_en && c < 20) begin @(negedge clk); c++; end
        check("t6_reached_run", bus.O_compute_en, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_outputs", all_outs(), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_pending", exp_q.size(), 0);

`ifdef SCHED_TIMEOUT_EN
        // watchdog fires after 100 RUN cycles
        push_pass(0,0,1,0);
        do_start(3, 2, 4, 1, 0);
        c = 0;
        while (!bus.O_ap_start && c < 20) begin @(negedge clk); c++; end
        c = 0; err_seen = 1'b0;
        while (!err_seen && c < 200) begin
            @(negedge clk); c++;
            err_seen = bus.O_err;
        end
        check("t7_err_latency", c, 101);
        check("t7_err_state", {err_seen, bus.O_busy, bus.O_compute_en}, 3'b100);
        pd_auto = 1'b1;
        repeat (3) @(negedge clk);
        push_pass(0,0,1,1); push_row(); push_layer();
        do_start(1, 1, 4, 1, 0);
        wait_done("t7_restart");
`else
        // no watchdog: RUN holds indefinitely
        push_pass(0,0,1,0);
        do_start(3, 2, 4, 1, 0);
        err_seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.O_err) err_seen = 1'b1;
        end
        check("t7_no_err_still_run", {err_seen, bus.O_compute_en}, 2'b01);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        pd_auto = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_no_pending", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_row_sched.md
Name: conv_row_sched

Overview:
- Row-level scheduler that sequences the convolution read-address controller.
- For each output row `oh` and kernel row `ky`, it computes the input row index, waits for that feature row to be ready, then opens one read pass by driving the address controller's start/compute-enable/ky/hindex inputs. It waits for the pass-done pulse before advancing.
- Emits accumulator first/last markers, a row-done pulse and a layer-done pulse to the downstream accumulator and writeback logic.

Parameters:
- AXIWIDTH, 32, width of configuration register inputs.
- DEPTHWIDTH, 9, buffer depth width; row indices are DEPTHWIDTH+1 bits.
- KWIDTH, 4, width of the ky index.
- TIMEOUT, 65535, watchdog limit in cycles (used only with the optional feature).

Ports:
- I_clk  in  1  clock
- I_rst  in  1  synchronous active-high reset
- I_ap_start  in  1  layer start; level or pulse, rising edge detected
- I_ky_num  in  AXIWIDTH  kernel height KH, 1..15
- I_oheight_num  in  AXIWIDTH  output rows OH, >=1
- I_iheight_num  in  AXIWIDTH  input rows IH
- I_stride  in  AXIWIDTH  vertical stride, 1..4
- I_pad  in  AXIWIDTH  top pad, < KH
- I_f_rdy  in  1  feature row for O_hindex resident (level)
- I_pass_done  in  1  one-cycle pulse from address controller at end of pass
- O_ap_start  out  1  one-cycle pass-start pulse to address controller
- O_compute_en  out  1  pass enable
- O_ky  out  KWIDTH  current kernel row
- O_hindex  out  DEPTHWIDTH+1  current input row
- O_acc_first  out  1  high during first executed pass of an output row
- O_acc_last  out  1  high during last ky pass of an output row
- O_row_done  out  1  one-cycle pulse after output row complete
- O_ap_done  out  1  one-cycle pulse after layer complete
- O_busy  out  1  high from start accept until O_ap_done
- O_err  out  1  one-cycle watchdog pulse (held 0 when feature absent)

Behaviour:
- Reset: every output is 0; state IDLE; all counters 0. Reset mid-layer aborts immediately with no done pulse.
- All outputs are registered.
- Start detection: rising edge of I_ap_start is detected as in the address controller (2-stage history). Edges seen while O_busy=1 are ignored.

State machine (IDLE, CALC, WAIT_RDY, START, RUN, NEXT, DONE):
- IDLE → CALC on start edge.
  - Latches all config inputs; oh=0, ky=0, row_base=-pad (signed, DEPTHWIDTH+2 bits); O_busy=1.
- CALC: row = row_base + ky.
  - If row<0 or row>=IH, the pass is skipped → NEXT.
  - Otherwise O_hindex<=row and O_ky<=ky → WAIT_RDY.
- WAIT_RDY → START when I_f_rdy=1.
- START: O_ap_start=1 for exactly this cycle; O_compute_en=1 from this cycle on → RUN.
- RUN: hold O_compute_en=1 until I_pass_done=1 → NEXT.
  - I_pass_done in any other state is ignored.
- NEXT: O_compute_en=0 for at least this cycle, so the address controller clears its counters.
  - If ky<KH-1: ky++ → CALC.
  - Else: O_row_done pulse; ky=0; row_base+=stride, incremental with no multiplier.
    - If oh==OH-1 → DONE.
    - Else oh++ → CALC.
- DONE: O_ap_done pulse; O_busy<=0 → IDLE.

Accumulator markers:
- O_acc_first=1 during START/RUN of the first non-skipped pass of the row.
- O_acc_last=1 during START/RUN when ky==KH-1, or when every later ky of the row will be skipped (bottom padding).
- pad<KH guarantees at least one executed pass per row.

Latency:
- Start edge sampled at edge N: CALC at N+1, WAIT_RDY at N+2; with I_f_rdy high, O_ap_start is high in cycle N+3.
- I_pass_done at edge M: NEXT at M+1; next O_ap_start no earlier than M+4.

Widths and boundaries:
- All counters are unsigned DEPTHWIDTH bits; row arithmetic is signed.
- KH=1 and OH=1 are legal: one pass, then row_done, then ap_done.
- I_f_rdy dropping during RUN has no effect.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts cycles in RUN and resets on entering RUN. On reaching TIMEOUT: O_err pulses, O_compute_en<=0, O_busy<=0, state → IDLE, and no O_ap_done is issued.
- Undefined: no counter is built, O_err is tied to 0, and RUN waits indefinitely.

Test Plan:
- KH=3, OH=2, IH=4, stride=1, pad=0, f_rdy=1, pass_done 5 cycles after each start → 6 passes; O_hindex=0,1,2,1,2,3; O_ky=0,1,2 repeating; 2 row_done pulses, 1 ap_done; acc_first on ky=0, acc_last on ky=2.
- KH=3, OH=4, IH=4, stride=1, pad=1 → row 0 skips ky=0 (acc_first on ky=1, hindex 0); row 3 skips ky=2 (acc_last on ky=1, hindex 3); 10 passes total.
- stride=2, KH=2, OH=2, IH=4, pad=0 → hindex sequence 0,1,2,3.
- f_rdy held low 20 cycles in WAIT_RDY → O_ap_start stays low; it asserts 1 cycle after f_rdy rises. Stray pass_done pulses in WAIT_RDY are ignored.
- Second start edge while busy is ignored; I_rst asserted mid-RUN → all outputs 0 next cycle, no ap_done.
- With SCHED_TIMEOUT_EN and TIMEOUT=100, pass_done withheld → O_err pulses after 100 RUN cycles, busy=0, a new start works. Without the macro → bench waits 1000 cycles and sees O_err=0 with compute_en still 1.
